display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Refresh scheduler for the shared 7-segment bus on the common-anode board. It time-shares the segment lines between N digit requesters and inserts a blanking interval before each digit to prevent ghosting. It skips disabled digits and double-buffers segment patterns so digits only change at frame boundaries. It sits between the per-digit decoders (number, syndrome, future status digits) and the board pins.

Parameters:
N_DIGITS, 2, number of digits/anodes scanned (1..8)
DIGIT_CYCLES, 1000, clk cycles per digit slot (27 MHz / 1000 = 27 kHz slot rate)
BLANK_CYCLES, 16, leading cycles of each slot with all anodes off; must be < DIGIT_CYCLES

Ports:
clk  in  1  system clock, 27 MHz
rst  in  1  synchronous, active-high reset
seg_in  in  7*N_DIGITS  segment patterns, active-low {a..g}; digit k at [7k+6:7k]
load  in  1  one-cycle strobe; captures seg_in into the pending buffer
digit_en  in  N_DIGITS  per-digit enable; 0 = digit skipped
seg  out  7  shared segment lines, active-low
an  out  N_DIGITS  anodes, active-low, at most one low at any time
frame_start  out  1  one-cycle pulse at start of each frame
cur_digit  out  3  index of the digit owning the current slot

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: seg=7'h7F, an=all 1, frame_start=0, cur_digit=0, state=IDLE, slot counter=0. Pending and active buffers are all 7'h7F. The pending-valid flag is 0.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: seg=7F, an=all 1. Moves to BLANK the first cycle digit_en != 0. cur_digit becomes the lowest enabled index. This starts a frame.
  - BLANK: lasts BLANK_CYCLES cycles with seg=7F and an=all 1. Then goes to SHOW.
  - SHOW: lasts DIGIT_CYCLES-BLANK_CYCLES cycles. an[cur_digit]=0 and seg=active[cur_digit].
  - End of SHOW: the next digit is the next enabled index above cur_digit, wrapping cyclically, using digit_en sampled that cycle. If none are enabled, go to IDLE. Otherwise go to BLANK.
- Frame start is either IDLE→BLANK, or a SHOW→BLANK transition whose new index is ≤ the old index (wrap).
  - frame_start is high during the first BLANK cycle of the frame.
  - Buffer swap happens in the same cycle: if pending-valid, active<=pending and pending-valid clears.
  - A single enabled digit therefore starts a new frame every slot.
- load: pending<=seg_in and pending-valid<=1. A second load before the swap overwrites pending (last wins). A load in the same cycle as a swap goes to pending and is kept for the next frame; the swap uses the old pending value.
- Latency: a load is visible no earlier than the next frame_start. Segments never change mid-frame.
- If digit_en[cur_digit] drops during SHOW, an goes all 1 and seg=7F on the next cycle. The slot still runs to its end, so timing is unchanged.
- Outputs seg, an, and frame_start are registered, so no combinational glitches reach the pins.
- Counter width is ceil(log2(DIGIT_CYCLES)). The counter resets to 0 on every state entry.
- rst mid-slot returns everything to reset values on the next edge. The buffers are blanked.

Optional Feature:
BRIGHTNESS_PWM_EN — adds input brightness[3:0].
- With the macro: during SHOW, the anode is driven low only while (SHOW cycle count mod 16) < brightness. brightness=0 keeps the digit dark; brightness=15 gives 15/16 duty. brightness is sampled at each SHOW entry.
- Without the macro: no port is added and SHOW drives the anode for the full SHOW duration.

Test Plan:
(Parameters for all scenarios: N=2, DIGIT_CYCLES=8, BLANK_CYCLES=2.)
1. Reset, then digit_en=2'b11, load with seg_in={7'h79,7'h40}.
   - frame_start fires; 2 cycles with an=11, seg=7F.
   - 6 cycles with an=10, seg=7'h40; 2 blank cycles; 6 cycles with an=01, seg=7'h79; then repeats.
2. Mid-frame load of {7'h24,7'h12} while digit 0 is shown.
   - Digit 1 still shows the old pattern.
   - The new patterns appear only after the next frame_start.
3. digit_en=2'b10 → only digit 1 scanned. frame_start every 8 cycles, cur_digit=1 constant, an never 2'b10.
4. digit_en cleared to 0 during SHOW of digit 0 → next cycle an=11, seg=7F. At slot end, FSM in IDLE. Re-enable → BLANK within 1 cycle plus frame_start.
5. Two loads before a frame boundary ({..0x01} then {..0x02}) → active gets the second. A load coinciding with frame_start is applied at the following frame.
6. rst asserted mid-SHOW → next cycle an=11, seg=7F, cur_digit=0. After release, both digits show 7F until a load.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-shares one active-low 7-segment bus across
// N_DIGITS common-anode digits. Each slot is BLANK_CYCLES of blanking
// followed by the SHOW period. Segment patterns are double-buffered and
// swapped only at frame start. BLANK_CYCLES is expected to be >= 1.
// Optional macro BRIGHTNESS_PWM_EN adds a 4-bit brightness input that
// gates the anode with a mod-16 PWM during SHOW.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 2,
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7*N_DIGITS-1:0]   seg_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     digit_en,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_start,
    output logic [2:0]              cur_digit
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                       state, nxt_state;
    logic [CW-1:0]                cnt, nxt_cnt;
    logic [2:0]                   nxt_digit, low_en, next_en;
    logic                         any_en, fs_d, swap, pwm_on;
    logic [6:0]                   seg_d;
    logic [N_DIGITS-1:0]          an_d;
    logic [N_DIGITS-1:0][6:0]     pend, act, act_nxt;
    logic                         pend_vld;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] bright_q, bright_use;
    // Brightness is latched on SHOW entry; the entry cycle itself uses the live input.
    always_comb begin
        bright_use = (state == SHOW) ? bright_q : brightness;
        pwm_on     = 4'(nxt_cnt) < bright_use;
    end

    // Hold the brightness sampled at SHOW entry for the rest of the slot.
    always_ff @(posedge clk) begin
        if (rst)
            bright_q <= 4'd0;
        else if (nxt_state == SHOW && state != SHOW)
            bright_q <= brightness;
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Next-state, next-digit search and the registered-output values.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_digit = cur_digit;
        fs_d      = 1'b0;
        low_en    = 3'd0;
        next_en   = cur_digit;
        any_en    = 1'b0;
        // Lowest enabled index (descending scan, last hit wins).
        for (int k = N_DIGITS - 1; k >= 0; k--)
            if (digit_en[k]) low_en = 3'(k);
        // Next enabled index strictly above cur_digit, cyclic; i = N_DIGITS
        // lands back on cur_digit itself (single enabled digit).
        for (int i = N_DIGITS; i >= 1; i--)
            for (int k = 0; k < N_DIGITS; k++)
                if (digit_en[k] && ((k == int'(cur_digit) + i) ||
                                    (k == int'(cur_digit) + i - N_DIGITS))) begin
                    next_en = 3'(k);
                    any_en  = 1'b1;
                end
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (|digit_en) begin
                    nxt_state = BLANK;
                    nxt_digit = low_en;
                    fs_d      = 1'b1;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = SHOW;
                    nxt_cnt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    nxt_cnt = '0;
                    if (!any_en) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_state = BLANK;
                        nxt_digit = next_en;
                        fs_d      = (next_en <= cur_digit);
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase

        swap    = fs_d & pend_vld;
        act_nxt = swap ? pend : act;

        // Digit is lit only in SHOW while still enabled (and PWM-on).
        seg_d = 7'h7F;
        an_d  = '1;
        for (int k = 0; k < N_DIGITS; k++)
            if (nxt_state == SHOW && k == int'(nxt_digit) && digit_en[k] && pwm_on) begin
                an_d[k] = 1'b0;
                seg_d   = act_nxt[k];
            end
    end

    // FSM state, slot counter and glitch-free registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cur_digit   <= 3'd0;
            seg         <= 7'h7F;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            cur_digit   <= nxt_digit;
            seg         <= seg_d;
            an          <= an_d;
            frame_start <= fs_d;
        end
    end

    // Pending/active double buffer; a load coincident with a swap lands in pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= {N_DIGITS{7'h7F}};
            act      <= {N_DIGITS{7'h7F}};
            pend_vld <= 1'b0;
        end else begin
            act      <= act_nxt;
            if (load)
                pend <= seg_in;
            pend_vld <= load | (pend_vld & ~swap);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with
// N=2, DIGIT_CYCLES=8, BLANK_CYCLES=2. Expected per-cycle pin values are
// queued ahead of time and compared on each falling edge.
module tb_display_scan_ctrl;

    localparam int N  = 2;
    localparam int DC = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic       fs;
        logic [1:0] an;
        logic [6:0] seg;
        logic [2:0] cur;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [13:0]   seg_in;
    logic          load;
    logic [1:0]    digit_en;
    logic [6:0]    seg;
    logic [1:0]    an;
    logic          frame_start;
    logic [2:0]    cur_digit;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    display_scan_ctrl #(.N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .load(load), .digit_en(digit_en),
        .seg(seg), .an(an), .frame_start(frame_start), .cur_digit(cur_digit)
    );

    always #5 clk = ~clk;

    task automatic push(input logic fs, input logic [1:0] a, input logic [6:0] s, input logic [2:0] c);
        exp_t e;
        e = '{fs: fs, an: a, seg: s, cur: c};
        q.push_back(e);
    endtask

    task automatic push_slot(input logic fs, input logic [2:0] c, input logic [1:0] a, input logic [6:0] s);
        push(fs, 2'b11, 7'h7F, c);
        for (int k = 1; k < BC; k++) push(1'b0, 2'b11, 7'h7F, c);
        for (int k = 0; k < DC - BC; k++) push(1'b0, a, s, c);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1);
        push_slot(1'b1, 3'd0, 2'b10, s0);
        push_slot(1'b0, 3'd1, 2'b01, s1);
    endtask

    task automatic test_reset();
        exp_t e, got;
        rst = 1'b1; load = 1'b0; seg_in = '0; digit_en = 2'b00;
        repeat (3) push(1'b0, 2'b11, 7'h7F, 3'd0);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
        end
    endtask

    task automatic test_basic_scan();
        exp_t e, got;
        rst = 1'b0; load = 1'b1; seg_in = {7'h79, 7'h40};
        push(1'b0, 2'b11, 7'h7F, 3'd0);
        push_frame(7'h40, 7'h79);
        push_frame(7'h40, 7'h79);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL basic_scan cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
            if (i == 0) begin load = 1'b0; digit_en = 2'b11; end
        end
    endtask

    task automatic test_midframe_load();
        exp_t e, got;
        push_frame(7'h40, 7'h79);
        push_frame(7'h12, 7'h24);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL midframe_load cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
            case (i)
                3: begin load = 1'b1; seg_in = {7'h24, 7'h12}; end
                4: load = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_double_load();
        exp_t e, got;
        push_frame(7'h12, 7'h24);
        push_frame(7'h02, 7'h22);
        push_frame(7'h03, 7'h33);
        push_frame(7'h04, 7'h44);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL double_load cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
            case (i)
                2:  begin load = 1'b1; seg_in = {7'h11, 7'h01}; end
                4:  begin load = 1'b1; seg_in = {7'h22, 7'h02}; end
                19: begin load = 1'b1; seg_in = {7'h33, 7'h03}; end
                31: begin load = 1'b1; seg_in = {7'h44, 7'h04}; end
                3, 5, 20, 32: load = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_single_digit();
        exp_t e, got;
        digit_en = 2'b10;
        repeat (3) push_slot(1'b1, 3'd1, 2'b01, 7'h44);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL single_digit cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
        end
    endtask

    task automatic test_disable_mid_show();
        exp_t e, got;
        digit_en = 2'b11;
        push(1'b1, 2'b11, 7'h7F, 3'd0);
        push(1'b0, 2'b11, 7'h7F, 3'd0);
        repeat (2) push(1'b0, 2'b10, 7'h04, 3'd0);
        repeat (8) push(1'b0, 2'b11, 7'h7F, 3'd0);
        push_slot(1'b1, 3'd0, 2'b10, 7'h04);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL disable_mid_show cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
            case (i)
                3:  digit_en = 2'b00;
                11: digit_en = 2'b11;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_show();
        exp_t e, got;
        push(1'b0, 2'b11, 7'h7F, 3'd1);
        push(1'b0, 2'b11, 7'h7F, 3'd1);
        repeat (2) push(1'b0, 2'b01, 7'h44, 3'd1);
        push(1'b0, 2'b11, 7'h7F, 3'd0);
        push_frame(7'h7F, 7'h7F);
        push_frame(7'h40, 7'h79);
        for (int i = 0; q.size() > 0; i++) begin
            @(negedge clk);
            e = q.pop_front(); got = {frame_start, an, seg, cur_digit};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_show cyc %0d: got fs=%b an=%b seg=%h cur=%0d, want fs=%b an=%b seg=%h cur=%0d",
                         i, got.fs, got.an, got.seg, got.cur, e.fs, e.an, e.seg, e.cur);
            end
            case (i)
                3: rst = 1'b1;
                4: rst = 1'b0;
                8: begin load = 1'b1; seg_in = {7'h79, 7'h40}; end
                9: load = 1'b0;
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_midframe_load();
        test_double_load();
        test_single_digit();
        test_disable_mid_show();
        test_reset_mid_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
